// File: rtl/mem_ctrl.sv
// Single-port RAM controller: valid/ready request and response channels,
// one transaction in flight, and saturating read/write completion counters.
module mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          rd_cnt_q;
  logic [7:0]          wr_cnt_q;
  logic                accept;
  logic                rsp_hs;

  assign accept = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_we ? WRITE : ISSUE;
      WRITE:   state_d = RESP;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe is qualified by reset combinationally so an aborted WRITE never reaches the RAM.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    ram_we    = (state_q == WRITE) && rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= 8'd0;
      wr_cnt_q <= 8'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == WRITE) begin
        rdata_q <= '0;
      end else if (state_q == CAPTURE) begin
        rdata_q <= ram_q;
      end
      if (rsp_hs) begin
        if (we_q) begin
          if (wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
        end else begin
          if (rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
        end
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a behavioural RAM plus a transaction-level
// model (memory image, saturating counters, latency and throughput expectations).
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_q;
  logic [7:0]  rd_count;
  logic [7:0]  wr_count;

  mem_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM: registered read, write on ram_we.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [15:0] model_mem [256];
  int          m_rd = 0;
  int          m_wr = 0;
  int          last_acc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Runs one full transaction; called and returns at a negedge with the DUT in IDLE.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                     input int stall);
    int          lat;
    logic [15:0] exp_data;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    last_acc  = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
    if (we) model_mem[addr] = wd;
    exp_data = we ? 16'h0 : model_mem[addr];
    @(negedge clk);
    chk("req_ready_busy", req_ready, 0);
    if (we) begin
      chk("ram_we_write", ram_we, 1);
      chk("ram_addr", ram_addr, addr);
      chk("ram_data", ram_data, wd);
    end else begin
      chk("ram_we_read", ram_we, 0);
    end
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, we ? 1 : 2);
    chk("ram_we_resp", ram_we, 0);
    chk("rsp_rdata", rsp_rdata, exp_data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_data);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (we) begin
      if (m_wr < 255) m_wr++;
    end else begin
      if (m_rd < 255) m_rd++;
    end
    @(negedge clk);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
    chk("wr_count", wr_count, m_wr);
    chk("rd_count", rd_count, m_rd);
    $display("txn %s addr=0x%02h data=0x%04h stall=%0d rsp=0x%04h rd=%0d wr=%0d",
             we ? "WR" : "RD", addr, wd, stall, exp_data, rd_count, wr_count);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rd = 0;
    m_wr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_acc;
    logic [15:0] d;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_we_after", ram_we, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);

    // Directed write then read of the same word, then a stalled read.
    txn(1'b1, 8'h10, 16'hBEEF, 0);
    txn(1'b0, 8'h10, 16'h0000, 0);
    txn(1'b0, 8'h10, 16'h0000, 5);

    // Reset landing on the WRITE cycle must suppress the write.
    txn(1'b1, 8'h20, 16'h5555, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ram_we", ram_we, 0);
    @(negedge clk);
    rst  = 1'b1;
    m_rd = 0;
    m_wr = 0;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_wr_count", wr_count, 0);
    chk("abort_ram_addr", ram_addr, 0);
    txn(1'b0, 8'h20, 16'h0000, 0);

    // Reset while a read response is pending discards it.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pend_rsp_valid", rsp_valid, 1);
    do_reset();
    chk("pend_rsp_dropped", rsp_valid, 0);
    chk("pend_rd_count", rd_count, 0);
    chk("pend_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;

    // Fill every word so later random reads have defined contents.
    for (int a = 0; a < 256; a++) begin
      d = 16'($urandom);
      txn(1'b1, 8'(a), d, 0);
    end
    do_reset();

    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    // Back-to-back writes: saturation and one accept every 3 cycles.
    do_reset();
    prev_acc = 0;
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom);
      txn(1'b1, 8'hFF, d, 0);
      if (i > 0) chk("b2b_gap", last_acc - prev_acc, 3);
      prev_acc = last_acc;
    end
    chk("sat_wr_count", wr_count, 255);
    txn(1'b0, 8'hFF, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
